// File: rtl/tlc5620_quad_dac_ctrl.sv
// Serial driver for the TLC5620 quad 8-bit DAC: shadow registers, round-robin frame scheduler, LOAD/LDAC.
// Optional macro DA_RAMP_GEN_EN replaces the write port with a built-in sawtooth source.
module tlc5620_quad_dac_ctrl #(
    parameter int CLK_DIV   = 32,
    parameter int CH_NUM    = 4,
    parameter int LDAC_MODE = 1
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [1:0] wr_ch,
    input  logic       wr_rng,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic       frame_done,
    output logic       DA_IO_CLK,
    output logic       DA_OUT_DATA,
    output logic       DA_LOAD,
    output logic       DA_LDAC
);

    typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_LOAD, S_LOAD_HOLD, S_LDAC} state_t;

    state_t      state, next_state;
    logic [15:0] tick_cnt;
    logic        tick;
    logic [4:0]  bit_cnt;
    logic [10:0] shift_reg;
    logic [8:0]  shadow [4];
    logic [3:0]  dirty;
    logic [1:0]  rr_ptr;
    logic [1:0]  pick_ch;
    logic        capture;
    logic        ldac_idle_n;
    logic        ldac_pulse_n;

    // Dirty bits above CH_NUM-1 are never set, so a mod-4 walk from rr_ptr matches a mod-CH_NUM walk.
    function automatic logic [1:0] pick_dirty(input logic [3:0] d, input logic [1:0] start);
        logic [1:0] sel;
        logic [1:0] idx;
        logic       found;
        sel   = start;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = start + 2'(i);
            if (!found && d[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign pick_ch = pick_dirty(dirty, rr_ptr);
    assign tick    = (state != S_IDLE) && (tick_cnt == 16'(CLK_DIV - 1));
    assign capture = (next_state == S_SHIFT) && (state != S_SHIFT);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= S_IDLE;
        else            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:      if (|dirty) next_state = S_SHIFT;
            S_SHIFT:     if (tick && bit_cnt == 5'd21) next_state = S_LOAD;
            S_LOAD:      if (tick) next_state = S_LOAD_HOLD;
            S_LOAD_HOLD: if (tick) begin
                             if (|dirty)              next_state = S_SHIFT;
                             else if (LDAC_MODE != 0) next_state = S_LDAC;
                             else                     next_state = S_IDLE;
                         end
            S_LDAC:      if (tick) next_state = S_IDLE;
            default:     next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy         = (state != S_IDLE);
        DA_LOAD      = (state != S_LOAD);
        frame_done   = (state == S_LOAD_HOLD) && (tick_cnt == 16'd0);
        ldac_pulse_n = (state != S_LDAC);
    end

    // In mode 0 LDAC is parked low, but only once reset has been released.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) ldac_idle_n <= 1'b1;
        else            ldac_idle_n <= 1'b0;
    end
    assign DA_LDAC = (LDAC_MODE != 0) ? ldac_pulse_n : ldac_idle_n;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)                      tick_cnt <= 16'd0;
        else if (state == S_IDLE || tick)    tick_cnt <= 16'd0;
        else                                 tick_cnt <= tick_cnt + 16'd1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rr_ptr <= 2'd0;
        end else if (capture) begin
            if (pick_ch == 2'(CH_NUM - 1)) rr_ptr <= 2'd0;
            else                           rr_ptr <= pick_ch + 2'd1;
        end
    end

    // Frame shifter: even ticks present the next bit with a rising clock, odd ticks drop the clock.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            shift_reg   <= 11'd0;
            bit_cnt     <= 5'd0;
            DA_IO_CLK   <= 1'b0;
            DA_OUT_DATA <= 1'b0;
        end else if (capture) begin
            shift_reg <= {pick_ch, shadow[pick_ch]};
            bit_cnt   <= 5'd0;
        end else if (state == S_SHIFT && tick) begin
            bit_cnt <= bit_cnt + 5'd1;
            if (!bit_cnt[0]) begin
                DA_OUT_DATA <= shift_reg[10];
                shift_reg   <= {shift_reg[9:0], 1'b0};
                DA_IO_CLK   <= 1'b1;
            end else begin
                DA_IO_CLK <= 1'b0;
            end
        end else if (state == S_LOAD && tick) begin
            DA_OUT_DATA <= 1'b0;
        end
    end

`ifdef DA_RAMP_GEN_EN
    logic [7:0] ramp;
    logic       ramp_load;

    assign wr_ready = 1'b0;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ramp      <= 8'd0;
            ramp_load <= 1'b1;
        end else begin
            ramp_load <= (state != S_IDLE) && (next_state == S_IDLE);
            if ((state != S_IDLE) && (next_state == S_IDLE)) ramp <= ramp + 8'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < 4; i++) shadow[i] <= 9'd0;
            dirty <= 4'd0;
        end else begin
            if (capture) dirty[pick_ch] <= 1'b0;
            if (ramp_load) begin
                for (int i = 0; i < 4; i++) begin
                    if (i < CH_NUM) begin
                        shadow[i] <= {1'b0, ramp + 8'(64 * i)};
                        dirty[i]  <= 1'b1;
                    end
                end
            end
        end
    end
`else
    logic wr_en;

    assign wr_ready = 1'b1;
    assign wr_en    = wr_valid && (int'(wr_ch) < CH_NUM);

    // A write landing on the capture cycle re-arms the channel: the frame carries the old value.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < 4; i++) shadow[i] <= 9'd0;
            dirty <= 4'd0;
        end else begin
            if (capture) dirty[pick_ch] <= 1'b0;
            if (wr_en) begin
                shadow[wr_ch] <= {wr_rng, wr_data};
                dirty[wr_ch]  <= 1'b1;
            end
        end
    end
`endif

endmodule
